// File: rtl/redmule_mx_pkg.sv
// redmule_mx_pkg: shared MX decoder / FP16 packer types and constants.
// Element widths, exponent biases, E8M0 scale and FP16 element typedefs.
package redmule_mx_pkg;

    localparam int MX_ELEM_W      = 8;
    localparam int FP16_W         = 16;
    localparam int BIAS_FP8       = 7;
    localparam int BIAS_FP16      = 15;
    localparam int MX_BLOCK_ELEMS = 32;

    // Shared block scale: pure power-of-two exponent, 0xFF encodes NaN.
    typedef logic [7:0] e8m0_t;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef logic [MX_ELEM_W-1:0] mx_elem_t;

    // True when an E8M0 scale encodes NaN.
    function automatic logic e8m0_is_nan(input e8m0_t s);
        return s == 8'hFF;
    endfunction

endpackage

// File: rtl/redmule_mx_fp16_packer_if.sv
// redmule_mx_fp16_packer_if: element-in / beat-out handshake bundle.
// flush_i exists only when REDMULE_MX_PACK_FLUSH_EN is defined.
interface redmule_mx_fp16_packer_if
    import redmule_mx_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int BITW   = FP16_W
);
    localparam int NUM_LANES = DATA_W / BITW;

    logic                 fp16_valid_i;
    logic                 fp16_ready_o;
    logic [BITW-1:0]      fp16_data_i;
    logic                 beat_valid_o;
    logic                 beat_ready_i;
    logic [DATA_W-1:0]    beat_data_o;
    logic [NUM_LANES-1:0] lane_mask_o;
    logic                 busy_o;
`ifdef REDMULE_MX_PACK_FLUSH_EN
    logic                 flush_i;

    modport master (
        output fp16_valid_i, fp16_data_i, beat_ready_i, flush_i,
        input  fp16_ready_o, beat_valid_o, beat_data_o, lane_mask_o, busy_o
    );

    modport slave (
        input  fp16_valid_i, fp16_data_i, beat_ready_i, flush_i,
        output fp16_ready_o, beat_valid_o, beat_data_o, lane_mask_o, busy_o
    );
`else
    modport master (
        output fp16_valid_i, fp16_data_i, beat_ready_i,
        input  fp16_ready_o, beat_valid_o, beat_data_o, lane_mask_o, busy_o
    );

    modport slave (
        input  fp16_valid_i, fp16_data_i, beat_ready_i,
        output fp16_ready_o, beat_valid_o, beat_data_o, lane_mask_o, busy_o
    );
`endif

endinterface

// File: rtl/redmule_mx_fp16_packer.sv
// redmule_mx_fp16_packer: packs serial FP16 elements into DATA_W-wide beats.
// Optional partial-beat flush enabled by REDMULE_MX_PACK_FLUSH_EN.
module redmule_mx_fp16_packer
    import redmule_mx_pkg::*;
#(
    parameter int DATA_W = 256,
    parameter int BITW   = FP16_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    redmule_mx_fp16_packer_if.slave bus
);

    localparam int NUM_LANES = DATA_W / BITW;
    localparam int CNT_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]    out_q, out_d;
    logic [DATA_W-1:0]    acc_wr;
    logic [NUM_LANES-1:0] mask_q, mask_d;
    logic                 vld_q, vld_d;

    logic slot_free;
    logic last_lane;
    logic ready;
    logic accept;
    logic complete;

`ifdef REDMULE_MX_PACK_FLUSH_EN
    logic                 pend_q, pend_d;
    logic                 flush_req;
    logic                 has_data;
    logic [CNT_W:0]       filled;
    logic [NUM_LANES-1:0] fill_mask;
`endif

    // Output register is free if empty or being drained this cycle.
    assign slot_free = !vld_q | bus.beat_ready_i;
    assign last_lane = (cnt_q == LAST_LANE);

`ifdef REDMULE_MX_PACK_FLUSH_EN
    // A pending flush blocks new elements until the partial beat leaves.
    assign ready = rst_ni & (!last_lane | slot_free) & !pend_q;
`else
    assign ready = rst_ni & (!last_lane | slot_free);
`endif

    assign accept   = bus.fp16_valid_i & ready;
    assign complete = accept & last_lane;

    assign bus.fp16_ready_o = ready;
    assign bus.beat_valid_o = vld_q;
    assign bus.beat_data_o  = out_q;
    assign bus.lane_mask_o  = mask_q;
    assign bus.busy_o       = (cnt_q != '0) | vld_q;

`ifdef REDMULE_MX_PACK_FLUSH_EN
    assign flush_req = bus.flush_i | pend_q;
    assign has_data  = (cnt_q != '0) | accept;
    assign filled    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, accept};

    // Thermometer mask of the lanes filled so far, including this cycle.
    always_comb begin
        fill_mask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            fill_mask[k] = (k < int'(filled));
        end
    end
`endif

    // Next-state: lane write, beat completion, drain and optional flush.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        out_d  = out_q;
        mask_d = mask_q;
        vld_d  = vld_q;
        acc_wr = acc_q;
`ifdef REDMULE_MX_PACK_FLUSH_EN
        pend_d = pend_q;
`endif
        if (accept) begin
            acc_wr[int'(cnt_q)*BITW +: BITW] = bus.fp16_data_i;
        end

        if (vld_q && bus.beat_ready_i) begin
            vld_d = 1'b0;
        end

        if (accept) begin
            acc_d = acc_wr;
            if (!last_lane) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (complete) begin
            out_d  = acc_wr;
            mask_d = '1;
            vld_d  = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
        end

`ifdef REDMULE_MX_PACK_FLUSH_EN
        if (complete) begin
            pend_d = 1'b0;
        end else if (flush_req) begin
            if (!has_data) begin
                pend_d = 1'b0;
            end else if (slot_free) begin
                out_d  = acc_wr;
                mask_d = fill_mask;
                vld_d  = 1'b1;
                cnt_d  = '0;
                acc_d  = '0;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            mask_q <= '0;
            vld_q  <= 1'b0;
`ifdef REDMULE_MX_PACK_FLUSH_EN
            pend_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            mask_q <= mask_d;
            vld_q  <= vld_d;
`ifdef REDMULE_MX_PACK_FLUSH_EN
            pend_q <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_redmule_mx_fp16_packer.sv
// tb_redmule_mx_fp16_packer: directed + random bench for the FP16 packer.
// Scoreboard rebuilds beats from the accepted element stream.
module tb_redmule_mx_fp16_packer;

    localparam int DATA_W = 256;
    localparam int BITW   = 16;
    localparam int NL     = DATA_W / BITW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    redmule_mx_fp16_packer_if #(.DATA_W(DATA_W), .BITW(BITW)) bus();

    redmule_mx_fp16_packer #(.DATA_W(DATA_W), .BITW(BITW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [BITW-1:0]   elems[$];
    logic [DATA_W-1:0] beats[$];
    logic [NL-1:0]     masks[$];
    int                beat_cyc[$];
    int                hold_viol = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [NL-1:0]     prev_mask;

    // Monitor: record accepted elements and delivered beats mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fp16_valid_i && bus.fp16_ready_o)
                elems.push_back(bus.fp16_data_i);
            if (prev_stall && (!bus.beat_valid_o ||
                bus.beat_data_o !== prev_data ||
                bus.lane_mask_o !== prev_mask))
                hold_viol++;
            if (bus.beat_valid_o && bus.beat_ready_i) begin
                beats.push_back(bus.beat_data_o);
                masks.push_back(bus.lane_mask_o);
                beat_cyc.push_back(cyc);
            end
            prev_stall = bus.beat_valid_o && !bus.beat_ready_i;
            prev_data  = bus.beat_data_o;
            prev_mask  = bus.lane_mask_o;
        end
    end

    // Reference: beat i is elements 16*i..16*i+15, first element in lane 0.
    function automatic logic [DATA_W-1:0] model_beat(input int idx);
        logic [DATA_W-1:0] b;
        b = '0;
        for (int k = 0; k < NL; k++) b[k*BITW +: BITW] = elems[idx*NL + k];
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] fill_beat(input logic [BITW-1:0] base, input int step);
        logic [DATA_W-1:0] b;
        for (int k = 0; k < NL; k++) b[k*BITW +: BITW] = base + BITW'(k * step);
        return b;
    endfunction

    task automatic clear_mon();
        elems.delete();
        beats.delete();
        masks.delete();
        beat_cyc.delete();
        hold_viol = 0;
    endtask

    task automatic send(input logic [BITW-1:0] d, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        bus.fp16_valid_i = 1'b1;
        bus.fp16_data_i  = d;
        while (n < 100) begin
            @(negedge clk);
            if (bus.fp16_ready_o) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        @(posedge clk); #1;
        bus.fp16_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fp16_valid_i = 1'b1;
        bus.fp16_data_i  = 16'h1234;
        bus.beat_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total += 3;
            if (bus.fp16_ready_o !== 1'b0) begin
                bad++; $display("FAIL reset_ready got=%b want=0", bus.fp16_ready_o);
            end
            if (bus.beat_valid_o !== 1'b0) begin
                bad++; $display("FAIL reset_bvalid got=%b want=0", bus.beat_valid_o);
            end
            if (bus.busy_o !== 1'b0) begin
                bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o);
            end
        end
        total += 2;
        if (bus.lane_mask_o !== '0) begin
            bad++; $display("FAIL reset_mask got=%h want=0", bus.lane_mask_o);
        end
        if (bus.beat_data_o !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", bus.beat_data_o);
        end
        @(posedge clk); #1;
        bus.fp16_valid_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_full_beat();
        bit ok;
        int nok;
        logic [DATA_W-1:0] exp;
        nok = 0;
        clear_mon();
        bus.beat_ready_i = 1'b1;
        for (int k = 0; k < NL; k++) begin
            send(16'h3C00 + 16'(k), ok);
            if (!ok) nok++;
        end
        exp = fill_beat(16'h3C00, 1);
        @(negedge clk);
        total += 4;
        if (nok != 0) begin
            bad++; $display("FAIL full_timeout got=%0d want=0", nok);
        end
        if (bus.beat_valid_o !== 1'b1) begin
            bad++; $display("FAIL full_latency got=%b want=1", bus.beat_valid_o);
        end
        if (bus.beat_data_o !== exp) begin
            bad++; $display("FAIL full_data got=%h want=%h", bus.beat_data_o, exp);
        end
        if (bus.lane_mask_o !== 16'hFFFF) begin
            bad++; $display("FAIL full_mask got=%h want=ffff", bus.lane_mask_o);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total += 2;
        if (bus.beat_valid_o !== 1'b0) begin
            bad++; $display("FAIL full_drain got=%b want=0", bus.beat_valid_o);
        end
        if (bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL full_idle_busy got=%b want=0", bus.busy_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok;
        int nok;
        int nbad;
        logic [DATA_W-1:0] e0, e1;
        nok = 0;
        nbad = 0;
        clear_mon();
        bus.beat_ready_i = 1'b0;
        for (int i = 0; i < 31; i++) begin
            send(16'h1000 + 16'(i), ok);
            if (!ok) nok++;
        end
        e0 = fill_beat(16'h1000, 1);
        e1 = fill_beat(16'h1010, 1);
        total++;
        if (nok != 0) begin
            bad++; $display("FAIL bp_timeout got=%0d want=0", nok);
        end
        bus.fp16_valid_i = 1'b1;
        bus.fp16_data_i  = 16'h101F;
        repeat (3) begin
            @(negedge clk);
            total += 2;
            if (bus.fp16_ready_o !== 1'b0) begin
                bad++; $display("FAIL bp_stall got=%b want=0", bus.fp16_ready_o);
            end
            if (bus.beat_valid_o !== 1'b1 || bus.beat_data_o !== e0) begin
                bad++; $display("FAIL bp_hold got=%h want=%h", bus.beat_data_o, e0);
            end
            @(posedge clk); #1;
        end
        bus.beat_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.fp16_ready_o !== 1'b1) begin
            bad++; $display("FAIL bp_release got=%b want=1", bus.fp16_ready_o);
        end
        @(posedge clk); #1;
        bus.fp16_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (bus.beat_valid_o !== 1'b1 || bus.beat_data_o !== e1) begin
            bad++; $display("FAIL bp_second got=%h want=%h", bus.beat_data_o, e1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total += 5;
        if (bus.beat_valid_o !== 1'b0) begin
            bad++; $display("FAIL bp_drain got=%b want=0", bus.beat_valid_o);
        end
        if (beats.size() != 2) begin
            bad++; $display("FAIL bp_count got=%0d want=2", beats.size());
        end else if (beats[0] !== e0 || beats[1] !== e1) begin
            bad++; $display("FAIL bp_beats got=%h want=%h", beats[1], e1);
        end
        if (elems.size() != 32) begin
            bad++; $display("FAIL bp_elems got=%0d want=32", elems.size());
        end else begin
            for (int i = 0; i < 32; i++)
                if (elems[i] !== 16'h1000 + 16'(i)) nbad++;
        end
        if (nbad != 0) begin
            bad++; $display("FAIL bp_order got=%0d want=0", nbad);
        end
        if (hold_viol != 0) begin
            bad++; $display("FAIL bp_stable got=%0d want=0", hold_viol);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        int nr;
        int nbad;
        nr = 0;
        nbad = 0;
        clear_mon();
        bus.beat_ready_i = 1'b1;
        bus.fp16_valid_i = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.fp16_data_i = 16'h2000 + 16'(i);
            @(negedge clk);
            if (!bus.fp16_ready_o) nr++;
            @(posedge clk); #1;
        end
        bus.fp16_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total += 3;
        if (nr != 0) begin
            bad++; $display("FAIL stream_ready got=%0d want=0", nr);
        end
        if (beats.size() != 4) begin
            bad++; $display("FAIL stream_count got=%0d want=4", beats.size());
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (beats[b] !== fill_beat(16'h2000 + 16'(b*NL), 1)) nbad++;
                if (b > 0 && beat_cyc[b] - beat_cyc[b-1] != NL) nbad++;
            end
        end
        if (nbad != 0) begin
            bad++; $display("FAIL stream_beats got=%0d want=0", nbad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        bus.beat_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) send(16'h5555, ok);
        @(negedge clk);
        total++;
        if (bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL rmid_busy got=%b want=1", bus.busy_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        @(negedge clk);
        total++;
        if (bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL rmid_cleared got=%b want=0", bus.busy_o);
        end
        @(posedge clk); #1;
        for (int i = 0; i < NL; i++) send(16'h4000, ok);
        repeat (3) @(posedge clk);
        #1;
        total += 2;
        if (beats.size() != 1) begin
            bad++; $display("FAIL rmid_count got=%0d want=1", beats.size());
        end else if (beats[0] !== fill_beat(16'h4000, 0)) begin
            bad++; $display("FAIL rmid_data got=%h want=%h", beats[0], fill_beat(16'h4000, 0));
        end
        if (masks.size() != 1 || masks[0] !== 16'hFFFF) begin
            bad++; $display("FAIL rmid_mask got=%0d want=1", masks.size());
        end
    endtask

    task automatic test_random();
        int n;
        int nbad;
        nbad = 0;
        clear_mon();
        for (int i = 0; i < 600; i++) begin
            bus.fp16_valid_i = ($urandom % 4) != 0;
            bus.fp16_data_i  = 16'($urandom);
            bus.beat_ready_i = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        bus.fp16_valid_i = 1'b0;
        bus.beat_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n = elems.size();
        @(negedge clk);
        total += 4;
        if (beats.size() != n / NL) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", beats.size(), n / NL);
        end else begin
            for (int b = 0; b < beats.size(); b++) begin
                if (beats[b] !== model_beat(b)) nbad++;
                if (masks[b] !== 16'hFFFF) nbad++;
            end
        end
        if (nbad != 0) begin
            bad++; $display("FAIL rand_beats got=%0d want=0", nbad);
        end
        if (bus.busy_o !== ((n % NL) != 0)) begin
            bad++; $display("FAIL rand_busy got=%b want=%b", bus.busy_o, (n % NL) != 0);
        end
        if (hold_viol != 0) begin
            bad++; $display("FAIL rand_stable got=%0d want=0", hold_viol);
        end
        @(posedge clk); #1;
    endtask

`ifdef REDMULE_MX_PACK_FLUSH_EN
    task automatic test_flush();
        bit ok;
        logic [DATA_W-1:0] exp;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_mon();
        bus.beat_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) send(16'h7C00, ok);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        exp = '0;
        for (int k = 0; k < 5; k++) exp[k*BITW +: BITW] = 16'h7C00;
        @(negedge clk);
        total += 3;
        if (bus.beat_valid_o !== 1'b1) begin
            bad++; $display("FAIL flush_valid got=%b want=1", bus.beat_valid_o);
        end
        if (bus.lane_mask_o !== 16'h001F) begin
            bad++; $display("FAIL flush_mask got=%h want=001f", bus.lane_mask_o);
        end
        if (bus.beat_data_o !== exp) begin
            bad++; $display("FAIL flush_data got=%h want=%h", bus.beat_data_o, exp);
        end
        @(posedge clk); #1;
        for (int k = 0; k < NL; k++) send(16'h0100 + 16'(k), ok);
        @(negedge clk);
        total += 2;
        if (bus.beat_data_o !== fill_beat(16'h0100, 1)) begin
            bad++; $display("FAIL flush_next got=%h want=%h", bus.beat_data_o, fill_beat(16'h0100, 1));
        end
        if (bus.lane_mask_o !== 16'hFFFF) begin
            bad++; $display("FAIL flush_next_mask got=%h want=ffff", bus.lane_mask_o);
        end
        @(posedge clk); #1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        total += 2;
        if (bus.beat_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush_noop got=%b want=0", bus.beat_valid_o);
        end
        if (bus.busy_o !== 1'b0) begin
            bad++; $display("FAIL flush_noop_busy got=%b want=0", bus.busy_o);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        bus.fp16_valid_i = 1'b0;
        bus.fp16_data_i  = '0;
        bus.beat_ready_i = 1'b0;
`ifdef REDMULE_MX_PACK_FLUSH_EN
        bus.flush_i = 1'b0;
`endif
        test_reset();
        test_full_beat();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_random();
`ifdef REDMULE_MX_PACK_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
